// File: rtl/ca_code_gen_if.sv
// Chip-rate control and C/A code output bundle between the code generator and
// its source/consumer.
interface ca_code_gen_if;
    logic       chip_en;
    logic [5:0] prn;
    logic       prn_load;
    logic       chip;
    logic       chip_valid;
    logic [9:0] chip_idx;
    logic       epoch;
    logic       running;
    logic       prn_err;

    modport master (
        output chip_en, prn, prn_load,
        input  chip, chip_valid, chip_idx, epoch, running, prn_err
    );

    modport slave (
        input  chip_en, prn, prn_load,
        output chip, chip_valid, chip_idx, epoch, running, prn_err
    );
endinterface

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold code generator: G1/G2 LFSR pair advanced once per chip-rate
// tick, PRN-selected G2 phase taps, code epoch flag and chip index.
module ca_code_gen #(
    parameter int CODE_LEN = 1023,
    parameter int N_PRN    = 32
) (
    input  logic         clk,
    input  logic         rst,
    ca_code_gen_if.slave bus
);
    localparam int IDX_W = 10;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [10:1]      r_g1;
    logic [10:1]      r_g2;
    logic [5:0]       r_prn_q;
    logic [IDX_W-1:0] r_count;
    logic             r_chip_p1;
    logic             r_vld_p1;
    logic [IDX_W-1:0] r_idx_p1;
    logic             r_epoch_p1;
    logic             r_prn_err;
    logic             w_prn_legal;
    logic             w_tick;
    logic             w_last;

    function automatic logic [10:1] g1_step(input logic [10:1] g);
        return {g[9:1], g[3] ^ g[10]};
    endfunction

    function automatic logic [10:1] g2_step(input logic [10:1] g);
        return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
    endfunction

    // G2 phase-select stage pair {s1, s2} per PRN.
    function automatic logic [7:0] g2_taps(input logic [5:0] p);
        logic [7:0] t;
        case (p)
            6'd1:  t = {4'd2, 4'd6};
            6'd2:  t = {4'd3, 4'd7};
            6'd3:  t = {4'd4, 4'd8};
            6'd4:  t = {4'd5, 4'd9};
            6'd5:  t = {4'd1, 4'd9};
            6'd6:  t = {4'd2, 4'd10};
            6'd7:  t = {4'd1, 4'd8};
            6'd8:  t = {4'd2, 4'd9};
            6'd9:  t = {4'd3, 4'd10};
            6'd10: t = {4'd2, 4'd3};
            6'd11: t = {4'd3, 4'd4};
            6'd12: t = {4'd5, 4'd6};
            6'd13: t = {4'd6, 4'd7};
            6'd14: t = {4'd7, 4'd8};
            6'd15: t = {4'd8, 4'd9};
            6'd16: t = {4'd9, 4'd10};
            6'd17: t = {4'd1, 4'd4};
            6'd18: t = {4'd2, 4'd5};
            6'd19: t = {4'd3, 4'd6};
            6'd20: t = {4'd4, 4'd7};
            6'd21: t = {4'd5, 4'd8};
            6'd22: t = {4'd6, 4'd9};
            6'd23: t = {4'd1, 4'd3};
            6'd24: t = {4'd4, 4'd6};
            6'd25: t = {4'd5, 4'd7};
            6'd26: t = {4'd6, 4'd8};
            6'd27: t = {4'd7, 4'd9};
            6'd28: t = {4'd8, 4'd10};
            6'd29: t = {4'd1, 4'd6};
            6'd30: t = {4'd2, 4'd7};
            6'd31: t = {4'd3, 4'd8};
            6'd32: t = {4'd4, 4'd9};
            default: t = 8'h00;
        endcase
        return t;
    endfunction

    function automatic logic code_bit(input logic [10:1] g1, input logic [10:1] g2,
                                      input logic [7:0] taps);
        logic b;
        b = g1[10];
        for (int i = 1; i <= 10; i++) begin
            if (4'(i) == taps[7:4] || 4'(i) == taps[3:0]) begin
                b = b ^ g2[i];
            end
        end
        return b;
    endfunction

    assign w_prn_legal = (bus.prn != '0) && (bus.prn <= 6'(N_PRN));
    // A load in the same cycle as a tick takes priority and drops the tick.
    assign w_tick      = (r_state == S_RUN) && bus.chip_en && !bus.prn_load;
    assign w_last      = (r_count == IDX_W'(CODE_LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (bus.prn_load) begin
            w_state_nxt = w_prn_legal ? S_RUN : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage p0 -> p1: LFSR state and count produce the registered chip outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g1       <= 10'h3FF;
            r_g2       <= 10'h3FF;
            r_prn_q    <= '0;
            r_count    <= '0;
            r_chip_p1  <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_idx_p1   <= '0;
            r_epoch_p1 <= 1'b0;
            r_prn_err  <= 1'b0;
        end else begin
            r_vld_p1   <= 1'b0;
            r_epoch_p1 <= 1'b0;
            if (bus.prn_load) begin
                r_g1     <= 10'h3FF;
                r_g2     <= 10'h3FF;
                r_count  <= '0;
                r_idx_p1 <= '0;
                if (w_prn_legal) begin
                    r_prn_q   <= bus.prn;
                    r_prn_err <= 1'b0;
                end else begin
                    r_prn_err <= 1'b1;
                end
            end else if (w_tick) begin
                r_chip_p1  <= code_bit(r_g1, r_g2, g2_taps(r_prn_q));
                r_idx_p1   <= r_count;
                r_vld_p1   <= 1'b1;
                r_epoch_p1 <= w_last;
                // Forcing all-ones at the wrap matches the natural period and
                // re-aligns the pair even if a register were ever upset.
                if (w_last) begin
                    r_count <= '0;
                    r_g1    <= 10'h3FF;
                    r_g2    <= 10'h3FF;
                end else begin
                    r_count <= r_count + 1'b1;
                    r_g1    <= g1_step(r_g1);
                    r_g2    <= g2_step(r_g2);
                end
            end
        end
    end

    assign bus.chip       = r_chip_p1;
    assign bus.chip_valid = r_vld_p1;
    assign bus.chip_idx   = r_idx_p1;
    assign bus.epoch      = r_epoch_p1;
    assign bus.running    = (r_state == S_RUN);
    assign bus.prn_err    = r_prn_err;
endmodule

// File: tb/tb_ca_code_gen.sv
// Directed and randomized checks of ca_code_gen against a sequence-level Gold
// code model and published first-chip octal values.
module tb_ca_code_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ca_code_gen_if bus();

    ca_code_gen #(.CODE_LEN(1023), .N_PRN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    int S1 [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int S2 [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    bit ref_code [1023];
    bit cap [2046];
    int m_idx;
    int n_cap;
    int n_epoch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gold code as sequences: g[n+10] recurrences from the two polynomials;
    // stage s at time n holds g[n+10-s].
    task automatic build_ref(input int p);
        bit g1 [1033];
        bit g2 [1033];
        for (int i = 0; i < 10; i++) begin
            g1[i] = 1'b1;
            g2[i] = 1'b1;
        end
        for (int n = 0; n + 10 < 1033; n++) begin
            g1[n+10] = g1[n+7] ^ g1[n];
            g2[n+10] = g2[n+8] ^ g2[n+7] ^ g2[n+4] ^ g2[n+2] ^ g2[n+1] ^ g2[n];
        end
        for (int n = 0; n < 1023; n++) begin
            ref_code[n] = g1[n] ^ g2[n + 10 - S1[p]] ^ g2[n + 10 - S2[p]];
        end
    endtask

    task automatic cyc(input bit ce, input bit pl, input int p);
        bus.chip_en  = ce;
        bus.prn_load = pl;
        bus.prn      = 6'(p);
        @(negedge clk);
    endtask

    task automatic load(input int p, input bit ce);
        bit legal;
        legal = (p >= 1) && (p <= 32);
        cyc(ce, 1'b1, p);
        chk("load_vld", 32'(bus.chip_valid), 32'd0);
        chk("load_idx", 32'(bus.chip_idx), 32'd0);
        chk("load_running", 32'(bus.running), 32'(legal));
        chk("load_prn_err", 32'(bus.prn_err), 32'(!legal));
        if (legal) begin
            build_ref(p);
            m_idx   = 0;
            n_cap   = 0;
            n_epoch = 0;
        end
    endtask

    task automatic tick_chk(input int gapmax);
        int g;
        int last;
        g = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
        last = (m_idx == 0) ? 1022 : m_idx - 1;
        for (int k = 0; k < g; k++) begin
            cyc(1'b0, 1'b0, 0);
            chk("gap_vld", 32'(bus.chip_valid), 32'd0);
            if (n_cap > 0) begin
                chk("hold_idx", 32'(bus.chip_idx), 32'(last));
                chk("hold_chip", 32'(bus.chip), 32'(ref_code[last]));
            end
        end
        cyc(1'b1, 1'b0, 0);
        chk("tick_vld", 32'(bus.chip_valid), 32'd1);
        chk("tick_idx", 32'(bus.chip_idx), 32'(m_idx));
        chk("tick_chip", 32'(bus.chip), 32'(ref_code[m_idx]));
        chk("tick_epoch", 32'(bus.epoch), 32'(m_idx == 1022));
        if (n_cap < 2046) cap[n_cap] = bus.chip;
        n_cap++;
        if (bus.epoch === 1'b1) n_epoch++;
        m_idx = (m_idx == 1022) ? 0 : m_idx + 1;
    endtask

    task automatic chk_octal(input string tag, input logic [9:0] oct);
        for (int i = 0; i < 10; i++) begin
            chk(tag, 32'(cap[i]), 32'(oct[9-i]));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_chip"}, 32'(bus.chip), 32'd0);
        chk({tag, "_vld"}, 32'(bus.chip_valid), 32'd0);
        chk({tag, "_idx"}, 32'(bus.chip_idx), 32'd0);
        chk({tag, "_epoch"}, 32'(bus.epoch), 32'd0);
        chk({tag, "_running"}, 32'(bus.running), 32'd0);
        chk({tag, "_prn_err"}, 32'(bus.prn_err), 32'd0);
    endtask

    initial begin
        int p;
        int bad;
        rst          = 1'b1;
        bus.chip_en  = 1'b0;
        bus.prn_load = 1'b0;
        bus.prn      = '0;
        m_idx   = 0;
        n_cap   = 0;
        n_epoch = 0;

        // Reset values, then ticks ignored while idle.
        repeat (3) cyc(1'b0, 1'b0, 0);
        chk_reset_outputs("reset");
        rst = 1'b0;
        cyc(1'b1, 1'b0, 0);
        chk("idle_vld", 32'(bus.chip_valid), 32'd0);
        cyc(1'b1, 1'b0, 0);
        chk("idle_running", 32'(bus.running), 32'd0);

        // First ten chips of PRN 1, 2, 3 against published octal values.
        load(1, 1'b0);
        repeat (10) tick_chk(2);
        chk_octal("octal_prn1", 10'o1440);
        load(2, 1'b0);
        repeat (10) tick_chk(0);
        chk_octal("octal_prn2", 10'o1620);
        load(3, 1'b0);
        repeat (10) tick_chk(1);
        chk_octal("octal_prn3", 10'o1710);

        load(32, 1'b0);
        repeat (40) tick_chk(1);

        // Two full periods: two epochs and a repeating code.
        load(1, 1'b0);
        repeat (2046) tick_chk(0);
        chk("epoch_count", 32'(n_epoch), 32'd2);
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            if (cap[i + 1023] != cap[i]) bad++;
        end
        chk("period_repeat", 32'(bad), 32'd0);

        // Illegal PRNs stop the generator and set the sticky error.
        load(0, 1'b0);
        repeat (3) begin
            cyc(1'b1, 1'b0, 0);
            chk("bad0_vld", 32'(bus.chip_valid), 32'd0);
        end
        load(int'($urandom_range(33, 63)), 1'b0);
        repeat (3) begin
            cyc(1'b1, 1'b0, 0);
            chk("bad33_vld", 32'(bus.chip_valid), 32'd0);
        end
        chk("bad_prn_err_sticky", 32'(bus.prn_err), 32'd1);
        load(5, 1'b0);
        repeat (12) tick_chk(2);

        // Load coincident with a tick at chip 500 drops the tick and restarts.
        load(7, 1'b0);
        repeat (500) tick_chk(0);
        p = int'($urandom_range(1, 32));
        load(p, 1'b1);
        cyc(1'b0, 1'b0, 0);
        chk("coinc_no_vld", 32'(bus.chip_valid), 32'd0);
        repeat (5) tick_chk(1);

        p = int'($urandom_range(1, 32));
        load(p, 1'b0);
        repeat (30) tick_chk(3);

        // Reset in the middle of a run.
        repeat (4) tick_chk(0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 0);
        rst = 1'b0;
        chk_reset_outputs("midrst");
        cyc(1'b1, 1'b0, 0);
        chk("midrst_idle_vld", 32'(bus.chip_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
